pll_supervisor: RTL and testbench
=================================

# pll_supervisor

Reset and lock supervisor for the board PLL. It runs on the free-running board reference clock. It drives the PLL's reset input and watches the PLL's asynchronous `locked` output. It produces a clean system reset for the PLL-clocked logic only after lock has been stable for a programmed time, and re-sequences the PLL on lock loss, lock timeout or software request.

## Interface
Parameters:
- SYNC_STAGES, 2 — flops in the `locked_in` synchronizer (min 2)
- RESET_PULSE, 16 — cycles `pll_rst` is held high per reset attempt (min 1)
- LOCK_HOLD, 1024 — cycles synced lock must stay high before release (min 1)
- LOCK_TIMEOUT, 65536 — cycles to wait for lock before retrying (min 1)

Ports:
- clkin  in  1  board reference clock (50 MHz), never gated
- rst  in  1  synchronous, active-high reset
- locked_in  in  1  PLL lock flag, asynchronous to clkin
- relock_req  in  1  single-cycle request to force a PLL reset sequence
- pll_rst  out  1  PLL reset, active high
- sys_rst  out  1  reset for PLL-domain logic, active high
- ready  out  1  high only in RUN
- fail_cnt  out  8  saturating count of WAIT_LOCK timeouts
- loss_cnt  out  8  saturating count of lock drops while in RUN

## Operation
- `locked_in` passes through a SYNC_STAGES flop chain; only its output `lk` is used.
- States: PULSE, WAIT_LOCK, HOLD, RUN. One shared down-counter `cnt`, sized to the largest parameter.
- PULSE:
  - pll_rst=1, sys_rst=1, ready=0.
  - On entry, cnt=RESET_PULSE-1; decrements each cycle.
  - At 0 → WAIT_LOCK with cnt=LOCK_TIMEOUT-1.
- WAIT_LOCK:
  - pll_rst=0, sys_rst=1.
  - lk=1 → HOLD with cnt=LOCK_HOLD-1.
  - Otherwise, at cnt=0 → PULSE and fail_cnt+1.
- HOLD:
  - pll_rst=0, sys_rst=1.
  - lk=0 → WAIT_LOCK with cnt reloaded to LOCK_TIMEOUT-1. Does not count as a failure.
  - lk=1 at cnt=0 → RUN.
- RUN:
  - sys_rst=0, ready=1.
  - lk=0 → PULSE and loss_cnt+1.
  - relock_req=1 → PULSE, no counter change.
- Priority:
  - In RUN, if lk=0 and relock_req arrive in the same cycle, the transition is taken once and loss_cnt increments.
  - relock_req is ignored outside RUN.
- fail_cnt and loss_cnt saturate at 255. They clear only on rst.
- rst at any time, including mid-sequence, forces the reset state below on the next edge.

## Timing
- Reset values:
  - state=PULSE, cnt=RESET_PULSE-1.
  - pll_rst=1, sys_rst=1, ready=0.
  - fail_cnt=0, loss_cnt=0.
  - Synchronizer flops=0.
- All outputs are registered and are a direct decode of the state register; there are no combinational paths from inputs.
- After rst falls, pll_rst stays high for exactly RESET_PULSE cycles.
- WAIT_LOCK reacts to lk in the cycle lk is seen. `locked_in` → `lk` latency is SYNC_STAGES cycles.
- With lock already present when WAIT_LOCK is entered, sys_rst falls exactly LOCK_HOLD cycles after HOLD entry.
- Lock loss in RUN: sys_rst and pll_rst rise SYNC_STAGES+1 cycles after `locked_in` falls.
- A lk glitch of at least one cycle during HOLD restarts qualification. Glitches shorter than a clkin period may be missed; this is acceptable.

## Structure
- Shared package `pll_supervisor_pkg` holds:
  - the state encoding constants (PULSE=0, WAIT_LOCK=1, HOLD=2, RUN=3);
  - the 8-bit counter width constant.
- Sub-module `sync_bit` is a parameterised SYNC_STAGES flop chain with a synchronous reset to 0. It is reused for other asynchronous flags in the design.
- Counter width is `$clog2(max(RESET_PULSE, LOCK_HOLD, LOCK_TIMEOUT))`, minimum 1.

## Test plan
All scenarios use SYNC_STAGES=2, RESET_PULSE=4, LOCK_HOLD=8, LOCK_TIMEOUT=32.

1. Lock present from the start:
   - Stimulus: rst high 3 cycles then low, locked_in=1 throughout.
   - Required: pll_rst high for 4 cycles, sys_rst low 8 cycles after HOLD entry, ready=1, both counters 0.
2. Lock never arrives:
   - Stimulus: locked_in=0 for 200 cycles.
   - Required: a 4-cycle pll_rst pulse every 36 cycles, fail_cnt increments once per pulse after the first, sys_rst stays 1.
3. Glitch during qualification:
   - Stimulus: in HOLD with cnt=3, drop locked_in for 1 cycle.
   - Required: state returns to WAIT_LOCK, full 8-cycle qualification restarts, fail_cnt unchanged.
4. Lock loss in RUN:
   - Stimulus: in RUN, drop locked_in.
   - Required: sys_rst=1, pll_rst=1 and ready=0 three cycles later, loss_cnt=1, full sequence repeats.
5. Software relock:
   - Stimulus: relock_req pulse in RUN, then the same pulse in WAIT_LOCK.
   - Required: the first pulse starts a new PULSE sequence with counters unchanged; the second pulse is ignored.
6. Saturation and reset mid-operation:
   - Stimulus: force 300 lock losses, then assert rst during HOLD.
   - Required: loss_cnt holds at 255; on rst all outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/pll_supervisor_pkg.sv
// Shared state encoding, statistics width and helpers for the PLL reset/lock supervisor.
package pll_supervisor_pkg;

    typedef enum logic [1:0] {
        PULSE     = 2'd0,
        WAIT_LOCK = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } sup_state_t;

    localparam int STAT_CNT_W = 8;

    // Width of the shared phase timer: enough bits for the largest (value-1) load, never zero.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        int w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic [STAT_CNT_W-1:0] sat_inc(input logic [STAT_CNT_W-1:0] v);
        return (v == '1) ? v : v + STAT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous flag, synchronously cleared to 0.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_supervisor.sv
// Sequences the PLL reset, qualifies lock for a hold time and only then releases the system reset.
module pll_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int RESET_PULSE  = 16,
    parameter int LOCK_HOLD    = 1024,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic                  clkin,
    input  logic                  rst,
    input  logic                  locked_in,
    input  logic                  relock_req,
    output logic                  pll_rst,
    output logic                  sys_rst,
    output logic                  ready,
    output logic [STAT_CNT_W-1:0] fail_cnt,
    output logic [STAT_CNT_W-1:0] loss_cnt
);

    localparam int CW = timer_width(RESET_PULSE, LOCK_HOLD, LOCK_TIMEOUT);
    localparam logic [CW-1:0] PULSE_LOAD   = CW'(RESET_PULSE - 1);
    localparam logic [CW-1:0] HOLD_LOAD    = CW'(LOCK_HOLD - 1);
    localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(LOCK_TIMEOUT - 1);

    logic lk;
    sup_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [STAT_CNT_W-1:0] fail_q, fail_d, loss_q, loss_d;
    logic pll_rst_q, sys_rst_q, ready_q;

    sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk_i (clkin),
        .rst_i (rst),
        .d_i   (locked_in),
        .q_o   (lk)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        loss_d  = loss_q;
        case (state_q)
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = TIMEOUT_LOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WAIT_LOCK: begin
                if (lk) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LOAD;
                    fail_d  = sat_inc(fail_q);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HOLD: begin
                // Any dropout restarts qualification from a fresh lock wait, not a PLL reset.
                if (!lk) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = TIMEOUT_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RUN: begin
                // Lock loss wins over a simultaneous relock request so it is always counted.
                if (!lk) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LOAD;
                    loss_d  = sat_inc(loss_q);
                end else if (relock_req) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LOAD;
                end
            end
            default: begin
                state_d = PULSE;
                cnt_d   = PULSE_LOAD;
            end
        endcase
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q   <= PULSE;
            cnt_q     <= PULSE_LOAD;
            fail_q    <= '0;
            loss_q    <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fail_q    <= fail_d;
            loss_q    <= loss_d;
            pll_rst_q <= (state_d == PULSE);
            sys_rst_q <= (state_d != RUN);
            ready_q   <= (state_d == RUN);
        end
    end

    assign pll_rst  = pll_rst_q;
    assign sys_rst  = sys_rst_q;
    assign ready    = ready_q;
    assign fail_cnt = fail_q;
    assign loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Self-checking bench for pll_supervisor: directed vector table, corner sequences and random stimulus vs a reference model.
module tb_pll_supervisor;

    localparam int SYNC = 2;
    localparam int RP   = 4;
    localparam int LH   = 8;
    localparam int LT   = 32;

    logic       clkin;
    logic       rst;
    logic       locked_in;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [7:0] fail_cnt;
    logic [7:0] loss_cnt;

    int n_pass  = 0;
    int n_total = 0;

    pll_supervisor #(
        .SYNC_STAGES  (SYNC),
        .RESET_PULSE  (RP),
        .LOCK_HOLD    (LH),
        .LOCK_TIMEOUT (LT)
    ) dut (
        .clkin      (clkin),
        .rst        (rst),
        .locked_in  (locked_in),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fail_cnt   (fail_cnt),
        .loss_cnt   (loss_cnt)
    );

    // ---------------- clock ----------------
    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    // ---------------- reference model ----------------
    typedef enum int {PH_RESETTING, PH_AWAITING, PH_QUALIFYING, PH_RUNNING} phase_t;
    phase_t m_phase;
    int     m_age;          // whole cycles spent in the current phase
    int     m_fail;
    int     m_loss;
    logic   m_hist[$];      // locked_in samples still travelling through the synchronizer
    bit     model_valid = 0;

    function automatic int bump(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic enter(input phase_t p);
        m_phase = p;
        m_age   = 0;
    endtask

    task automatic model_step();
        logic lk_seen;
        if (rst) begin
            enter(PH_RESETTING);
            m_fail = 0;
            m_loss = 0;
            m_hist = {};
            for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
            model_valid = 1;
            return;
        end
        lk_seen = m_hist.pop_front();
        m_hist.push_back(locked_in);
        case (m_phase)
            PH_RESETTING: if (m_age >= RP - 1) enter(PH_AWAITING); else m_age++;
            PH_AWAITING: begin
                if (lk_seen) enter(PH_QUALIFYING);
                else if (m_age >= LT - 1) begin enter(PH_RESETTING); m_fail = bump(m_fail); end
                else m_age++;
            end
            PH_QUALIFYING: begin
                if (!lk_seen) enter(PH_AWAITING);
                else if (m_age >= LH - 1) enter(PH_RUNNING);
                else m_age++;
            end
            default: begin
                if (!lk_seen) begin enter(PH_RESETTING); m_loss = bump(m_loss); end
                else if (relock_req) enter(PH_RESETTING);
            end
        endcase
    endtask

    function automatic int pack_out(input logic p, input logic s, input logic r, input int f, input int l);
        return (int'(p) << 18) | (int'(s) << 17) | (int'(r) << 16) | ((f & 255) << 8) | (l & 255);
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- driver ----------------
    task automatic cycle();
        @(posedge clkin);
        model_step();
        #1;
        if (model_valid)
            check("model", pack_out(pll_rst, sys_rst, ready, int'(fail_cnt), int'(loss_cnt)),
                  pack_out(m_phase == PH_RESETTING, m_phase != PH_RUNNING, m_phase == PH_RUNNING,
                           m_fail, m_loss));
    endtask

    task automatic wait_level(input bit sel_ready, input logic val, input int budget, input string name);
        int n;
        n = 0;
        while (((sel_ready ? ready : pll_rst) !== val) && n < budget) begin
            cycle();
            n++;
        end
        check(name, int'(sel_ready ? ready : pll_rst), int'(val));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic rst;
        logic locked;
        logic relock;
        int   cycles;
        logic pll;
        logic sys;
        logic rdy;
        int   fail;
        int   loss;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic lk, input logic rl, input int n,
                       input logic p, input logic s, input logic y, input int f, input int l);
        vec_t v;
        v.rst = r; v.locked = lk; v.relock = rl; v.cycles = n;
        v.pll = p; v.sys = s; v.rdy = y; v.fail = f; v.loss = l;
        vecs.push_back(v);
    endtask

    initial begin
        int len;
        rst        = 1'b1;
        locked_in  = 1'b1;
        relock_req = 1'b0;

        // rst  lk rl  n   pll sys rdy fail loss
        add(1, 1, 0, 3,   1, 1, 0, 0, 0);   // held in reset
        add(0, 1, 0, 3,   1, 1, 0, 0, 0);   // pll_rst still high 3 cycles after rst falls
        add(0, 1, 0, 1,   0, 1, 0, 0, 0);   // 4th cycle: pulse ends
        add(0, 1, 0, 8,   0, 1, 0, 0, 0);   // lock seen, qualifying
        add(0, 1, 0, 1,   0, 0, 1, 0, 0);   // released 8 cycles after HOLD entry
        add(0, 1, 0, 5,   0, 0, 1, 0, 0);
        add(0, 0, 0, 2,   0, 0, 1, 0, 0);   // lock drop still in the synchronizer
        add(0, 0, 0, 1,   1, 1, 0, 0, 1);   // third cycle: back to PULSE, loss counted
        add(0, 1, 0, 3,   1, 1, 0, 0, 1);
        add(0, 1, 0, 1,   0, 1, 0, 0, 1);
        add(0, 1, 0, 8,   0, 1, 0, 0, 1);
        add(0, 1, 0, 1,   0, 0, 1, 0, 1);   // full sequence repeated
        add(0, 1, 1, 1,   1, 1, 0, 0, 1);   // relock in RUN, counters unchanged
        add(0, 0, 0, 4,   0, 1, 0, 0, 1);   // now waiting, no lock
        add(0, 0, 1, 1,   0, 1, 0, 0, 1);   // relock ignored while waiting
        add(0, 0, 0, 30,  0, 1, 0, 0, 1);
        add(0, 0, 0, 1,   1, 1, 0, 1, 1);   // timeout: new pulse, fail=1
        add(0, 0, 0, 3,   1, 1, 0, 1, 1);
        add(0, 0, 0, 1,   0, 1, 0, 1, 1);   // 4-cycle pulse
        add(0, 0, 0, 31,  0, 1, 0, 1, 1);
        add(0, 0, 0, 1,   1, 1, 0, 2, 1);   // period of 36 cycles

        foreach (vecs[i]) begin
            rst        = vecs[i].rst;
            locked_in  = vecs[i].locked;
            relock_req = vecs[i].relock;
            repeat (vecs[i].cycles) cycle();
            check($sformatf("vec%0d", i),
                  pack_out(pll_rst, sys_rst, ready, int'(fail_cnt), int'(loss_cnt)),
                  pack_out(vecs[i].pll, vecs[i].sys, vecs[i].rdy, vecs[i].fail, vecs[i].loss));
        end
        relock_req = 1'b0;

        // Glitch while qualifying: dropout reaches the FSM when its hold timer reads 3.
        locked_in = 1'b1;
        wait_level(0, 1'b0, 12, "glitch_wait_entry");
        repeat (3) cycle();
        locked_in = 1'b0;
        cycle();
        locked_in = 1'b1;
        repeat (5) cycle();
        check("glitch_no_early_run", int'(ready), 0);
        repeat (5) cycle();
        check("glitch_still_holding", int'(ready), 0);
        cycle();
        check("glitch_requalified_run", int'(ready), 1);
        check("glitch_fail_unchanged", int'(fail_cnt), 2);

        // 300 lock losses: loss_cnt must stick at 255.
        for (int i = 0; i < 300; i++) begin
            locked_in = 1'b0;
            wait_level(0, 1'b1, 8, "loss_pulse");
            locked_in = 1'b1;
            wait_level(1, 1'b1, 30, "loss_rerun");
        end
        check("loss_saturated", int'(loss_cnt), 255);
        check("loss_fail_unchanged", int'(fail_cnt), 2);

        // Reset asserted while qualifying.
        relock_req = 1'b1;
        cycle();
        relock_req = 1'b0;
        wait_level(0, 1'b0, 10, "mid_rst_wait_entry");
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        check("mid_rst_pll_rst", int'(pll_rst), 1);
        check("mid_rst_sys_rst", int'(sys_rst), 1);
        check("mid_rst_ready", int'(ready), 0);
        check("mid_rst_fail_cnt", int'(fail_cnt), 0);
        check("mid_rst_loss_cnt", int'(loss_cnt), 0);
        rst = 1'b0;
        repeat (3) cycle();
        check("post_rst_pulse_held", int'(pll_rst), 1);
        cycle();
        check("post_rst_pulse_end", int'(pll_rst), 0);

        // Random lock behaviour, relock requests and occasional resets.
        for (int seg = 0; seg < 120; seg++) begin
            len       = $urandom_range(1, 60);
            locked_in = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < len; k++) begin
                relock_req = ($urandom_range(0, 29) == 0);
                rst        = ($urandom_range(0, 399) == 0);
                cycle();
            end
        end
        rst        = 1'b0;
        relock_req = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
